// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A clock divider produces a
// one-clk pixel strobe. Horizontal and vertical counters advance on that
// strobe, and sync, display-enable and line/frame pulses are decoded from
// them. The decoded sync/enable are delayed by PIPE_DEPTH pixels so they
// stay aligned with downstream colour stages.
//
// Optional feature macro: VGA_TIMING_TESTPAT_EN
//   defined   : tp_rgb carries 8 vertical colour bars, aligned with display_en
//   undefined : tp_rgb is tied to 0 and no pattern logic is built
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous, active-low reset
//   pix_ce       out  pixel strobe, high for one clk per pixel
//   hcount       out  current pixel column (undelayed)
//   vcount       out  current line (undelayed)
//   display_en   out  active-area flag, delayed PIPE_DEPTH pixels
//   h_sync       out  horizontal sync, delayed PIPE_DEPTH pixels, H_POL level
//   v_sync       out  vertical sync, delayed PIPE_DEPTH pixels, V_POL level
//   line_start   out  one-clk pulse on the pixel strobe where hcount == 0
//   frame_start  out  one-clk pulse on the pixel strobe where hcount == vcount == 0
//   frame_count  out  frames completed, mod 256
//   tp_rgb       out  test-pattern colour {R,G,B}, 4 bits each
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DEPTH = 1,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          pix_ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          display_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count,
  output logic [11:0]   tp_rgb
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic HPOL   = (H_POL != 0);
  localparam logic VPOL   = (V_POL != 0);

  // -------------------------------------------------------------------------
  // Pixel strobe
  // -------------------------------------------------------------------------
  logic w_div_wrap;

  generate
    if (CLK_DIV == 1) begin : g_nodiv
      assign w_div_wrap = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      logic [DW-1:0] r_div;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_div <= '0;
        end else if (r_div == DW'(CLK_DIV - 1)) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      assign w_div_wrap = (r_div == DW'(CLK_DIV - 1));
    end
  endgenerate

  // Gating with reset_n keeps the strobe (and the pulses derived from it)
  // low while reset is held, including the CLK_DIV == 1 case.
  assign pix_ce = reset_n & w_div_wrap;

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic [7:0]    r_frame_count;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (int'(r_hcount) == H_TOTAL - 1);
  assign w_v_last = (int'(r_vcount) == V_TOTAL - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_count <= '0;
    end else if (w_div_wrap) begin
      if (w_h_last) begin
        r_hcount <= '0;
        if (w_v_last) begin
          r_vcount      <= '0;
          r_frame_count <= r_frame_count + 8'd1;
        end else begin
          r_vcount <= r_vcount + 1'b1;
        end
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_count = r_frame_count;
  assign line_start  = pix_ce & (r_hcount == '0);
  assign frame_start = line_start & (r_vcount == '0);

  // -------------------------------------------------------------------------
  // Raw decode and alignment pipe. Stage contents are active-high flags
  // {de, hs, vs}; polarity is applied only at the output so a cleared
  // stage always reads as "sync inactive".
  // -------------------------------------------------------------------------
  logic       w_de_raw;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [2:0] r_pipe [PIPE_DEPTH];

  assign w_de_raw = (int'(r_hcount) < H_VISIBLE) && (int'(r_vcount) < V_VISIBLE);
  assign w_hs_raw = (int'(r_hcount) >= HS_START) && (int'(r_hcount) < HS_END);
  assign w_vs_raw = (int'(r_vcount) >= VS_START) && (int'(r_vcount) < VS_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (w_div_wrap) begin
      r_pipe[0] <= {w_de_raw, w_hs_raw, w_vs_raw};
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign display_en = r_pipe[PIPE_DEPTH-1][2];
  assign h_sync     = HPOL ? r_pipe[PIPE_DEPTH-1][1] : ~r_pipe[PIPE_DEPTH-1][1];
  assign v_sync     = VPOL ? r_pipe[PIPE_DEPTH-1][0] : ~r_pipe[PIPE_DEPTH-1][0];

  // -------------------------------------------------------------------------
  // Colour-bar test pattern
  // -------------------------------------------------------------------------
`ifdef VGA_TIMING_TESTPAT_EN
  localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;

  logic [CW-1:0] r_bar_cnt;
  logic [2:0]    r_bar_idx;
  logic [11:0]   w_bar_rgb;
  logic [11:0]   w_tp_raw;
  logic [11:0]   r_tp_pipe [PIPE_DEPTH];

  // Bar position tracks hcount: both restart together at the line wrap,
  // so the index never needs a divide. It wraps freely in blanking where
  // the enable masks it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_div_wrap) begin
      if (w_h_last) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (int'(r_bar_cnt) == BAR_W - 1) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_bar_rgb = 12'h000;
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 12'hFFF;
      3'd1:    w_bar_rgb = 12'hFF0;
      3'd2:    w_bar_rgb = 12'h0FF;
      3'd3:    w_bar_rgb = 12'h0F0;
      3'd4:    w_bar_rgb = 12'hF0F;
      3'd5:    w_bar_rgb = 12'hF00;
      3'd6:    w_bar_rgb = 12'h00F;
      default: w_bar_rgb = 12'h000;
    endcase
  end

  assign w_tp_raw = w_de_raw ? w_bar_rgb : 12'h000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_tp_pipe[i] <= '0;
      end
    end else if (w_div_wrap) begin
      r_tp_pipe[0] <= w_tp_raw;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_tp_pipe[i] <= r_tp_pipe[i-1];
      end
    end
  end

  assign tp_rgb = display_en ? r_tp_pipe[PIPE_DEPTH-1] : 12'h000;
`else
  assign tp_rgb = 12'h000;
`endif

endmodule
